// File: rtl/ram_sync_param.sv
// rtl/ram_sync_param.sv - parametrised single-port synchronous RAM with a zeroing init FSM
// Optional feature macro MEM_PARITY_EN: stores an even-parity bit per word and reports perr on read.
module ram_sync_param #(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             rvalid,
   output logic             busy,
   output logic             perr
);

`ifdef MEM_PARITY_EN
   localparam int MW = WIDTH + 1;
`else
   localparam int MW = WIDTH;
`endif

   typedef enum logic {INIT, IDLE} state_t;

   state_t        state;
   logic [AW-1:0] ptr;
   logic [MW-1:0] mem [DEPTH];

   logic          in_range;
   logic          req_ok;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [MW-1:0] mem_wword;
   logic [MW-1:0] rd_word;

   // Compare one bit wider so a power-of-two DEPTH does not truncate to zero.
   assign in_range  = {1'b0, addr} < (AW+1)'(DEPTH);
   assign req_ok    = (state == IDLE) && !clear;
   assign mem_we    = (state == INIT) || (req_ok && wr_en && in_range);
   assign mem_waddr = (state == INIT) ? ptr : addr;
   assign rd_word   = in_range ? mem[addr] : '0;

`ifdef MEM_PARITY_EN
   assign mem_wword = (state == INIT) ? '0 : {^wdata, wdata};
`else
   assign mem_wword = (state == INIT) ? '0 : wdata;
`endif

   // The array has no reset; the INIT sequence is what clears it.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wword;
      end
   end

`ifdef MEM_PARITY_EN
   logic perr_q;
   assign perr = perr_q;
`else
   assign perr = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= INIT;
         ptr    <= '0;
         busy   <= 1'b1;
         rvalid <= 1'b0;
         rdata  <= '0;
`ifdef MEM_PARITY_EN
         perr_q <= 1'b0;
`endif
      end else begin
         rvalid <= 1'b0;
`ifdef MEM_PARITY_EN
         perr_q <= 1'b0;
`endif
         case (state)
            INIT: begin
               if (clear) begin
                  ptr <= '0;
               end else if (ptr == AW'(DEPTH - 1)) begin
                  state <= IDLE;
                  ptr   <= '0;
                  busy  <= 1'b0;
               end else begin
                  ptr <= ptr + AW'(1);
               end
            end
            IDLE: begin
               if (clear) begin
                  state <= INIT;
                  ptr   <= '0;
                  busy  <= 1'b1;
               end else if (rd_en) begin
                  rvalid <= 1'b1;
                  // Write-first: a same-cycle write returns the new data.
                  if (!in_range) begin
                     rdata <= '0;
                  end else if (wr_en) begin
                     rdata <= wdata;
                  end else begin
                     rdata <= rd_word[WIDTH-1:0];
                  end
`ifdef MEM_PARITY_EN
                  perr_q <= in_range && !wr_en && (^rd_word);
`endif
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule
